// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: word size, canonical NOP, fetch FSM states.
package rv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- substituted for the data of a faulting fetch
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  // One buffered fetch entry is {pc, instruction, fault}
  localparam int FETCH_ENTRY_W = 2 * XLEN + 1;

  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_FETCH = 2'd1,
    IFU_HALT  = 2'd2
  } ifu_state_e;

  // Clear the byte offset so every fetch address is word aligned
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched entries until decode consumes them.
// The head is read combinationally from storage; a pushed entry becomes visible
// the cycle after the push. Flush empties the FIFO in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 65
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only accepted when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only observed through a valid head, so no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the fetch PC, issues in-order pipelined requests to
// instruction memory under a credit limit, buffers responses and hands them to
// decode. Redirect flushes the buffer and drops every response still in flight.
// Handshakes: a transfer happens in a cycle where valid && ready are both high at
// the rising edge; a valid request keeps its address stable until it is accepted.
module instruction_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction_code,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output ifu_state_e  fsm_state
);

  localparam int             CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]    CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

  ifu_state_e               state;
  ifu_state_e               state_next;
  logic [31:0]              pc;
  logic [31:0]              rsp_pc;
  logic [31:0]              redirect_word;
  logic [CW-1:0]            outstanding;
  logic [CW-1:0]            outstanding_next;
  logic [CW-1:0]            drop;
  logic [CW-1:0]            fifo_count;
  logic [CW:0]              credit_used;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FETCH_ENTRY_W-1:0] fifo_in;
  logic [FETCH_ENTRY_W-1:0] fifo_head;
  logic                     req_fire;
  logic                     rsp_drop;
  logic                     push;
  logic                     pop;

  assign redirect_word = align_word(redirect_pc);

  // Every issued request reserves a buffer slot until its entry is consumed
  assign credit_used      = {1'b0, outstanding} + {1'b0, fifo_count};
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

  // Responses belonging to the pre-redirect stream (or arriving with a redirect) are discarded
  assign rsp_drop = imem_rsp_valid && ((drop != '0) || redirect_valid);
  assign push     = imem_rsp_valid && !rsp_drop;
  assign fifo_in  = {rsp_pc, (imem_rsp_err ? RV_NOP : imem_rsp_data), imem_rsp_err};
  assign pop      = inst_valid && inst_ready && !redirect_valid;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_in),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IFU_IDLE;
    else        state <= state_next;
  end

  // FSM next state: start after reset, stop on a delivered bus error, resume on redirect
  always_comb begin
    state_next = state;
    case (state)
      IFU_IDLE:  state_next = IFU_FETCH;
      IFU_FETCH: if (push && imem_rsp_err) state_next = IFU_HALT;
      IFU_HALT:  if (redirect_valid) state_next = IFU_FETCH;
      default:   state_next = IFU_IDLE;
    endcase
  end

  // FSM outputs: request only while fetching, with credit left, and not in a redirect cycle
  always_comb begin
    imem_req_valid = 1'b0;
    if (state == IFU_FETCH && credit_used < CREDIT_MAX && !fifo_full && !redirect_valid)
      imem_req_valid = 1'b1;
  end

  // Fetch PC, response PC tracker and in-flight / drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        pc     <= redirect_word;
        rsp_pc <= redirect_word;
        drop   <= outstanding_next;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        // responses after a redirect come back in order from consecutive addresses
        if (push) rsp_pc <= rsp_pc + 32'd4;
        if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
      end
    end
  end

  assign imem_req_addr    = pc;
  assign inst_valid       = !fifo_empty;
  assign inst_pc          = inst_valid ? fifo_head[FETCH_ENTRY_W-1 -: 32] : 32'h0;
  assign instruction_code = inst_valid ? fifo_head[32:1] : 32'h0;
  assign inst_fault       = inst_valid && fifo_head[0];
  assign fsm_state        = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: an in-order memory model with configurable latency,
// a table of cycle-by-cycle expectations after reset, directed corner sequences,
// and a scoreboard comparing every consumed instruction against an expected queue.
module tb_instruction_fetch;
  import rv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction_code;
  logic [31:0] inst_pc;
  logic        inst_fault;
  ifu_state_e  fsm_state;

  instruction_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .imem_rsp_err     (imem_rsp_err),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .instruction_code (instruction_code),
    .inst_pc          (inst_pc),
    .inst_fault       (inst_fault),
    .fsm_state        (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model and scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        req_ready;
    logic        inst_ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_inst_valid;
    logic [31:0] exp_inst_pc;
    logic [31:0] exp_code;
  } vec_t;

  mreq_t       mem_q[$];
  logic [64:0] exp_q[$];
  vec_t        vecs[9];
  int          cyc;
  int          lat;
  logic        err_en;
  logic [31:0] err_addr;
  int          fire_cnt;
  logic        fire_now;
  logic [31:0] last_fire_addr;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[31:2], 2'b11} ^ 32'h00A5_5A00;
  endfunction

  function automatic logic [64:0] exp_entry(input logic [31:0] pc, input logic fault);
    return {pc, (fault ? 32'h0000_0013 : mem_word(pc)), fault};
  endfunction

  function automatic vec_t mk(input logic rv, input logic [31:0] ra, input logic iv,
                              input logic [31:0] ipc);
    vec_t v;
    v.req_ready      = 1'b1;
    v.inst_ready     = 1'b1;
    v.exp_req_valid  = rv;
    v.exp_req_addr   = ra;
    v.exp_inst_valid = iv;
    v.exp_inst_pc    = iv ? ipc : 32'h0;
    v.exp_code       = iv ? mem_word(ipc) : 32'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Samples handshakes and consumed entries at the negedge, then advances to
  // just after the next posedge and drives the memory response for the new cycle.
  task automatic tick();
    mreq_t m;
    @(negedge clk);
    fire_now = imem_req_valid && imem_req_ready;
    if (fire_now) begin
      fire_cnt++;
      last_fire_addr = imem_req_addr;
    end
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %0h code %0h, required no instruction", inst_pc,
                 instruction_code);
      end else begin
        chk("sb_entry", {inst_pc, instruction_code, inst_fault}, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      mem_q.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_err   = 1'b0;
    end else begin
      if (fire_now) begin
        m.addr = last_fire_addr;
        m.due  = cyc + lat - 1;
        mem_q.push_back(m);
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        m = mem_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(m.addr);
        imem_rsp_err   = err_en && (m.addr == err_addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
      end
    end
  endtask

  // Leaves the bench just after a posedge with rst_n freshly released (cycle R)
  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    err_en         = 1'b0;
    err_addr       = 32'h0;
    lat            = 1;
    mem_q.delete();
    tick();
    tick();
    fire_cnt = 0;
    rst_n    = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    fire_cnt = 0;
    fire_now = 1'b0;
    last_fire_addr = 32'h0;
    rst_n    = 1'b0;

    // Cycle-by-cycle behaviour after reset release with a 1-cycle memory and
    // decode always ready: two requests per three cycles with a 2-entry buffer.
    vecs[0] = mk(1'b0, 32'h8000_0000, 1'b0, 32'h0);
    vecs[1] = mk(1'b1, 32'h8000_0000, 1'b0, 32'h0);
    vecs[2] = mk(1'b1, 32'h8000_0004, 1'b0, 32'h0);
    vecs[3] = mk(1'b0, 32'h8000_0008, 1'b1, 32'h8000_0000);
    vecs[4] = mk(1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004);
    vecs[5] = mk(1'b1, 32'h8000_000C, 1'b0, 32'h0);
    vecs[6] = mk(1'b0, 32'h8000_0010, 1'b1, 32'h8000_0008);
    vecs[7] = mk(1'b1, 32'h8000_0010, 1'b1, 32'h8000_000C);
    vecs[8] = mk(1'b1, 32'h8000_0014, 1'b0, 32'h0);

    // 1: reset release, streaming fetch
    do_reset();
    #1;
    chk("rst_state", fsm_state, IFU_IDLE);
    chk("rst_fault", inst_fault, 1'b0);
    exp_q.push_back(exp_entry(32'h8000_0000, 1'b0));
    exp_q.push_back(exp_entry(32'h8000_0004, 1'b0));
    exp_q.push_back(exp_entry(32'h8000_0008, 1'b0));
    exp_q.push_back(exp_entry(32'h8000_000C, 1'b0));
    for (int k = 0; k < 9; k++) begin
      imem_req_ready = vecs[k].req_ready;
      inst_ready     = vecs[k].inst_ready;
      #1;
      chk($sformatf("t1_req_valid[%0d]", k), imem_req_valid, vecs[k].exp_req_valid);
      chk($sformatf("t1_req_addr[%0d]", k), imem_req_addr, vecs[k].exp_req_addr);
      chk($sformatf("t1_inst_valid[%0d]", k), inst_valid, vecs[k].exp_inst_valid);
      chk($sformatf("t1_inst_pc[%0d]", k), inst_pc, vecs[k].exp_inst_pc);
      chk($sformatf("t1_code[%0d]", k), instruction_code, vecs[k].exp_code);
      tick();
    end
    wait_drain("t1_drain", 0);

    // 2: decode stalled for 10 cycles -> credit limits requests, stream resumes in order
    do_reset();
    inst_ready = 1'b0;
    exp_q.push_back(exp_entry(32'h8000_0000, 1'b0));
    exp_q.push_back(exp_entry(32'h8000_0004, 1'b0));
    exp_q.push_back(exp_entry(32'h8000_0008, 1'b0));
    exp_q.push_back(exp_entry(32'h8000_000C, 1'b0));
    for (int i = 0; i < 10; i++) tick();
    #1;
    chk("t2_fires_stalled", fire_cnt, 2);
    chk("t2_req_valid_stalled", imem_req_valid, 1'b0);
    chk("t2_head_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    wait_drain("t2_drain", 40);

    // 3: redirect with two requests in flight (3-cycle memory)
    do_reset();
    lat = 3;
    exp_q.push_back(exp_entry(32'h0000_0100, 1'b0));
    tick();
    tick();
    tick();
    chk("t3_inflight", fire_cnt, 2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1;
    chk("t3_req_in_redirect", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3_inst_valid_after", inst_valid, 1'b0);
    begin
      int n;
      n = 0;
      while (fire_cnt == 2 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t3_new_fire", fire_cnt, 3);
    chk("t3_new_addr", last_fire_addr, 32'h0000_0100);
    wait_drain("t3_drain", 40);

    // 4: bus error on 8000_0008 halts fetch; redirect restarts it
    do_reset();
    err_en   = 1'b1;
    err_addr = 32'h8000_0008;
    exp_q.push_back(exp_entry(32'h8000_0000, 1'b0));
    exp_q.push_back(exp_entry(32'h8000_0004, 1'b0));
    exp_q.push_back(exp_entry(32'h8000_0008, 1'b1));
    exp_q.push_back(exp_entry(32'h8000_000C, 1'b0));
    for (int i = 0; i < 15; i++) tick();
    #1;
    chk("t4_fires", fire_cnt, 4);
    chk("t4_halt", fsm_state, IFU_HALT);
    chk("t4_req_valid_halt", imem_req_valid, 1'b0);
    wait_drain("t4_drain", 0);
    err_en = 1'b0;
    exp_q.push_back(exp_entry(32'h8000_0000, 1'b0));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0000;
    #1;
    chk("t4_req_in_redirect", imem_req_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_restart_state", fsm_state, IFU_FETCH);
    chk("t4_restart_valid", imem_req_valid, 1'b1);
    chk("t4_restart_addr", imem_req_addr, 32'h8000_0000);
    wait_drain("t4_restart_drain", 40);

    // 5: memory not ready -> address held, single request issued
    do_reset();
    imem_req_ready = 1'b0;
    exp_q.push_back(exp_entry(32'h8000_0000, 1'b0));
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i > 0) chk($sformatf("t5_hold_valid[%0d]", i), imem_req_valid, 1'b1);
      chk($sformatf("t5_hold_addr[%0d]", i), imem_req_addr, 32'h8000_0000);
      tick();
    end
    chk("t5_no_fire", fire_cnt, 0);
    imem_req_ready = 1'b1;
    tick();
    chk("t5_one_fire", fire_cnt, 1);
    chk("t5_fire_addr", last_fire_addr, 32'h8000_0000);
    #1;
    chk("t5_next_addr", imem_req_addr, 32'h8000_0004);
    wait_drain("t5_drain", 40);

    // 6a: PC wrap from FFFF_FFFC to 0 (redirect target has its low bits cleared)
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    exp_q.push_back(exp_entry(32'hFFFF_FFFC, 1'b0));
    exp_q.push_back(exp_entry(32'h0000_0000, 1'b0));
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t6_wrap_valid", imem_req_valid, 1'b1);
    chk("t6_wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    #1;
    chk("t6_wrap_addr1", imem_req_addr, 32'h0000_0000);
    wait_drain("t6_wrap_drain", 40);

    // 6b: reset asserted mid-stream clears every output immediately
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #1;
    chk("t6_pre_valid", inst_valid, 1'b1);
    chk("t6_pre_pc", inst_pc, 32'h8000_0000);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req_valid", imem_req_valid, 1'b0);
    chk("t6_rst_req_addr", imem_req_addr, 32'h8000_0000);
    chk("t6_rst_inst_valid", inst_valid, 1'b0);
    chk("t6_rst_code", instruction_code, 32'h0);
    chk("t6_rst_pc", inst_pc, 32'h0);
    chk("t6_rst_fault", inst_fault, 1'b0);
    chk("t6_rst_state", fsm_state, IFU_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
